// File: rtl/add_tree_reduce.sv
// add_tree_reduce: iterative sum/max reduction of N_IN operands using N_ADD shared combine units
module add_tree_reduce #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 7,
  parameter int N_ADD = 2
) (
  input  logic                  clk,
  input  logic                  r_enable,
  input  logic [N_IN*WIDTH-1:0] init_data,
  input  logic                  op_max,
  output logic                  busy,
  output logic                  w_enable,
  output logic [WIDTH-1:0]      result,
  output logic                  overflow
);
  localparam int NU  = (N_ADD < N_IN / 2) ? N_ADD : N_IN / 2;
  localparam int NUS = (NU > 0) ? NU : 1;
  localparam int KW  = $clog2(N_IN + 1);
  typedef enum logic [1:0] {COMPUTE, FINISH, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] slot   [N_IN];
  logic [WIDTH-1:0] slot_n [N_IN];
  logic [WIDTH-1:0] comb_out [NUS];
  logic [NUS-1:0]   comb_co;
  logic [KW-1:0]    k, k_n;
  logic             mode, carry, carry_n;
  int               p;
  // pairs always sit at the front, so unit u permanently serves slots 2u and 2u+1
  if (NU > 0) begin : g_units
    for (genvar u = 0; u < NU; u++) begin : g_u
      logic [WIDTH:0] s;
      assign s           = {1'b0, slot[2*u]} + {1'b0, slot[2*u+1]};
      assign comb_out[u] = mode ? ((slot[2*u] > slot[2*u+1]) ? slot[2*u] : slot[2*u+1]) : s[WIDTH-1:0];
      assign comb_co[u]  = s[WIDTH];
    end
  end else begin : g_none
    assign comb_out[0] = '0;
    assign comb_co     = '0;
  end
  // combines used this round: min(N_ADD, floor(k/2))
  always_comb begin
    p = int'(k) / 2;
    p = (p > NU) ? NU : p;
  end
  // one reduction round: combined pairs first, unpaired survivors compacted behind them
  always_comb begin
    carry_n = carry;
    for (int d = 0; d < N_IN; d++)
      slot_n[d] = (d < int'(k) - p) ? slot[d+p] : slot[d];
    for (int d = 0; d < NU; d++)
      if (d < p) begin
        slot_n[d] = comb_out[d];
        carry_n   = carry_n | (comb_co[d] & ~mode);
      end
    k_n = KW'(int'(k) - p);
  end
  // state register; r_enable restarts from any state
  always_ff @(posedge clk)
    if (r_enable) state <= (N_IN > 1) ? COMPUTE : FINISH;
    else state <= state_n;
  // next state
  always_comb
    state_n = (state == COMPUTE) ? ((int'(k) - p == 1) ? FINISH : COMPUTE) :
              (state == FINISH)  ? DONE : state;
  // status outputs decoded from state
  always_comb begin
    busy     = (state == COMPUTE);
    w_enable = (state == DONE);
  end
  // datapath: load, reduce, then capture result
  always_ff @(posedge clk)
    if (r_enable) begin
      for (int i = 0; i < N_IN; i++) slot[i] <= init_data[i*WIDTH +: WIDTH];
      k        <= KW'(N_IN);
      mode     <= op_max;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (state == COMPUTE) begin
      slot  <= slot_n;
      k     <= k_n;
      carry <= carry_n;
    end else if (state == FINISH) begin
      result   <= slot[0];
      overflow <= carry & ~mode;
    end
endmodule

// File: tb/tb_add_tree_reduce.sv
// tb_add_tree_reduce: directed checks of add_tree_reduce across four parameter sets
module tb_add_tree_reduce;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  logic         r_ab = 1'b0, m_ab = 1'b0;
  logic [223:0] d_ab = '0;
  logic         busy_a, w_a, ov_a, busy_b, w_b, ov_b;
  logic [31:0]  res_a, res_b;
  logic         r_c = 1'b0, m_c = 1'b0;
  logic [31:0]  d_c = '0;
  logic         busy_c, w_c, ov_c;
  logic [7:0]   res_c;
  logic         r_d = 1'b0, m_d = 1'b0;
  logic [31:0]  d_d = '0;
  logic         busy_d, w_d, ov_d;
  logic [31:0]  res_d;
  add_tree_reduce dut_a (.clk(clk), .r_enable(r_ab), .init_data(d_ab), .op_max(m_ab),
    .busy(busy_a), .w_enable(w_a), .result(res_a), .overflow(ov_a));
  add_tree_reduce #(.N_ADD(4)) dut_b (.clk(clk), .r_enable(r_ab), .init_data(d_ab), .op_max(m_ab),
    .busy(busy_b), .w_enable(w_b), .result(res_b), .overflow(ov_b));
  add_tree_reduce #(.WIDTH(8), .N_IN(4), .N_ADD(2)) dut_c (.clk(clk), .r_enable(r_c), .init_data(d_c),
    .op_max(m_c), .busy(busy_c), .w_enable(w_c), .result(res_c), .overflow(ov_c));
  add_tree_reduce #(.N_IN(1)) dut_d (.clk(clk), .r_enable(r_d), .init_data(d_d), .op_max(m_d),
    .busy(busy_d), .w_enable(w_d), .result(res_d), .overflow(ov_d));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic run_c(input logic [31:0] d, input logic m, input logic [7:0] exp_res, input logic exp_ov);
    d_c = d; m_c = m; r_c = 1'b1;
    tick;
    r_c = 1'b0;
    check("c_rst_busy", busy_c, 1); check("c_rst_w", w_c, 0); check("c_rst_ov", ov_c, 0);
    for (int e = 1; e <= 3; e++) begin
      tick;
      check("c_busy", busy_c, e < 2); check("c_w", w_c, e == 3);
    end
    check("c_res", res_c, exp_res); check("c_ov", ov_c, exp_ov);
  endtask
  initial begin
    for (int i = 0; i < 7; i++) d_ab[i*32 +: 32] = 32'(i + 1);
    r_ab = 1'b1;
    tick;
    r_ab = 1'b0;
    check("a_rst_busy", busy_a, 1); check("a_rst_w", w_a, 0); check("a_rst_ov", ov_a, 0);
    check("b_rst_busy", busy_b, 1); check("b_rst_w", w_b, 0);
    for (int e = 1; e <= 5; e++) begin
      tick;
      check("a_busy", busy_a, e < 4); check("a_w", w_a, e == 5);
      check("b_busy", busy_b, e < 3); check("b_w", w_b, e >= 4);
    end
    check("a_res", res_a, 28); check("a_ov", ov_a, 0);
    check("b_res", res_b, 28); check("b_ov", ov_b, 0);
    run_c({8'd1, 8'd1, 8'd100, 8'd200}, 1'b0, 8'd46, 1'b1);
    run_c({8'd1, 8'd1, 8'd100, 8'd200}, 1'b1, 8'd200, 1'b0);
    d_c = {8'd1, 8'd1, 8'd100, 8'd200}; m_c = 1'b0; r_c = 1'b1;
    tick;
    r_c = 1'b0;
    tick;
    run_c({8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, 8'd10, 1'b0);
    d_d = 32'h1234; r_d = 1'b1;
    tick;
    r_d = 1'b0;
    check("d_rst_busy", busy_d, 0); check("d_rst_w", w_d, 0); check("d_rst_ov", ov_d, 0);
    for (int e = 1; e <= 3; e++) begin
      tick;
      check("d_busy", busy_d, 0); check("d_w", w_d, 1); check("d_res", res_d, 32'h1234);
    end
    r_ab = 1'b1;
    tick;
    r_ab = 1'b0;
    tick;
    for (int i = 0; i < 7; i++) d_ab[i*32 +: 32] = 32'd5;
    r_ab = 1'b1;
    tick;
    r_ab = 1'b0;
    check("rl_w0", w_a, 0);
    for (int e = 1; e <= 5; e++) begin
      tick;
      check("rl_w", w_a, e == 5);
    end
    check("rl_res", res_a, 35); check("rl_ov", ov_a, 0);
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < 7; i++) d_ab[i*32 +: 32] = $urandom;
      m_ab = 1'($urandom);
      tick;
      check("hold_res", res_a, 35); check("hold_w", w_a, 1); check("hold_ov", ov_a, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
